transaction_assembler: RTL and testbench

Upstream stage for the validator. It receives transactions as a framed byte stream (valid/last) and packs each 16-byte frame into one 128-bit transaction. It emits that transaction as a single-cycle valid pulse, matching the validator's `i_valid`/`i_transcation` input. Malformed frames (short, long, stalled) are dropped, flagged and counted, so only well-formed 128-bit transactions reach the difficulty filter.

---
 rtl/transaction_assembler.sv | 137 +++++++++++++
 tb/tb_transaction_assembler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/transaction_assembler.sv
// Packs 16-byte framed byte streams into 128-bit transactions for the validator.
// Short, long and stalled frames are dropped, flagged with a one-cycle pulse and counted.
module transaction_assembler #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_byte_valid,
    input  logic [7:0]       i_byte,
    input  logic             i_byte_last,
    output logic             o_valid,
    output logic [127:0]     o_transaction,
    output logic             o_err_short,
    output logic             o_err_long,
    output logic             o_err_timeout,
    output logic [CNT_W-1:0] o_frame_count,
    output logic [CNT_W-1:0] o_err_count
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // The limit is hit on the idle cycle that would take the count to TIMEOUT_CYCLES.
    localparam logic [TW-1:0] IDLE_LIMIT = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    state_t         state;
    logic [3:0]     index;
    logic [TW-1:0]  idle_cnt;
    logic [119:0]   byte_buf;
    logic           timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (idle_cnt == IDLE_LIMIT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            index         <= '0;
            idle_cnt      <= '0;
            byte_buf      <= '0;
            o_valid       <= 1'b0;
            o_transaction <= '0;
            o_err_short   <= 1'b0;
            o_err_long    <= 1'b0;
            o_err_timeout <= 1'b0;
            o_frame_count <= '0;
            o_err_count   <= '0;
        end else begin
            o_valid       <= 1'b0;
            o_err_short   <= 1'b0;
            o_err_long    <= 1'b0;
            o_err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    index    <= '0;
                    idle_cnt <= '0;
                    if (i_byte_valid) begin
                        if (i_byte_last) begin
                            o_err_short <= 1'b1;
                            o_err_count <= sat_inc(o_err_count);
                        end else begin
                            byte_buf <= {byte_buf[111:0], i_byte};
                            index    <= 4'd1;
                            state    <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (i_byte_valid) begin
                        idle_cnt <= '0;
                        if (index != 4'd15) begin
                            if (i_byte_last) begin
                                o_err_short <= 1'b1;
                                o_err_count <= sat_inc(o_err_count);
                                index       <= '0;
                                state       <= IDLE;
                            end else begin
                                byte_buf <= {byte_buf[111:0], i_byte};
                                index    <= index + 4'd1;
                            end
                        end else if (i_byte_last) begin
                            // The first 15 bytes sit in the buffer oldest-first, giving big-endian order.
                            o_transaction <= {byte_buf, i_byte};
                            o_valid       <= 1'b1;
                            o_frame_count <= sat_inc(o_frame_count);
                            index         <= '0;
                            state         <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (timeout_hit) begin
                        o_err_timeout <= 1'b1;
                        o_err_count   <= sat_inc(o_err_count);
                        idle_cnt      <= '0;
                        index         <= '0;
                        state         <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end
                DRAIN: begin
                    if (i_byte_valid) begin
                        idle_cnt <= '0;
                        if (i_byte_last) begin
                            o_err_long  <= 1'b1;
                            o_err_count <= sat_inc(o_err_count);
                            index       <= '0;
                            state       <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        o_err_timeout <= 1'b1;
                        o_err_count   <= sat_inc(o_err_count);
                        idle_cnt      <= '0;
                        index         <= '0;
                        state         <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end
                default: begin
                    index    <= '0;
                    idle_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transaction_assembler.sv
// Directed bench for transaction_assembler: a frame-level vector table plus
// hand-written sequences for timeout, the timeout race, mid-frame reset and saturation.
module tb_transaction_assembler;

    logic         clk = 1'b0;
    logic         rst;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_last;
    logic         o_valid;
    logic [127:0] o_transaction;
    logic         o_err_short;
    logic         o_err_long;
    logic         o_err_timeout;
    logic [1:0]   o_frame_count;
    logic [1:0]   o_err_count;

    int   checks = 0;
    int   errors = 0;
    logic early;

    always #5 clk = ~clk;

    transaction_assembler #(
        .TIMEOUT_CYCLES(4),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_byte_valid(byte_valid),
        .i_byte(byte_data),
        .i_byte_last(byte_last),
        .o_valid(o_valid),
        .o_transaction(o_transaction),
        .o_err_short(o_err_short),
        .o_err_long(o_err_long),
        .o_err_timeout(o_err_timeout),
        .o_frame_count(o_frame_count),
        .o_err_count(o_err_count)
    );

    typedef struct {
        int           nbytes;
        logic [7:0]   base;
        logic         rand_gaps;
        logic         exp_valid;
        logic         exp_short;
        logic         exp_long;
        logic [1:0]   exp_fc;
        logic [1:0]   exp_ec;
        logic [127:0] exp_word;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of input, then sample just after the clock edge.
    task automatic applyStimulus(input logic v, input logic [7:0] b, input logic l);
        byte_valid = v;
        byte_data  = b;
        byte_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic noteEarly();
        early = early | o_valid | o_err_short | o_err_long | o_err_timeout;
    endtask

    task automatic sendFrame(input int n, input logic [7:0] base, input logic rand_gaps);
        early = 1'b0;
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, base + 8'(k), k == n - 1);
            if (k < n - 1) begin
                noteEarly();
                if (rand_gaps) begin
                    int g;
                    g = $urandom_range(0, 3);
                    for (int j = 0; j < g; j++) begin
                        applyStimulus(1'b0, 8'h00, 1'b0);
                        noteEarly();
                    end
                end
            end
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 128'h000102030405060708090A0B0C0D0E0F};
        vecs[1] = '{16, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 128'h101112131415161718191A1B1C1D1E1F};
        vecs[2] = '{16, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 128'h202122232425262728292A2B2C2D2E2F};
        vecs[3] = '{5,  8'h30, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd1, 128'h202122232425262728292A2B2C2D2E2F};
        vecs[4] = '{1,  8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd2, 128'h202122232425262728292A2B2C2D2E2F};
        vecs[5] = '{16, 8'h50, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd2, 128'h505152535455565758595A5B5C5D5E5F};
        vecs[6] = '{20, 8'h60, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd3, 128'h505152535455565758595A5B5C5D5E5F};
        vecs[7] = '{16, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 2'd3, 128'h808182838485868788898A8B8C8D8E8F};
        vecs[8] = '{5,  8'h90, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd3, 128'h808182838485868788898A8B8C8D8E8F};

        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        doReset();

        checkOutput("reset valid", o_valid, 1'b0);
        checkOutput("reset pulses", {o_err_short, o_err_long, o_err_timeout}, 3'b000);
        checkOutput("reset word", o_transaction, 128'h0);
        checkOutput("reset frame_count", o_frame_count, 2'd0);
        checkOutput("reset err_count", o_err_count, 2'd0);

        // Frames follow each other with no idle cycles between them.
        for (int i = 0; i < 9; i++) begin
            sendFrame(vecs[i].nbytes, vecs[i].base, vecs[i].rand_gaps);
            checkOutput($sformatf("v%0d early pulse", i), early, 1'b0);
            checkOutput($sformatf("v%0d valid", i), o_valid, vecs[i].exp_valid);
            checkOutput($sformatf("v%0d err_short", i), o_err_short, vecs[i].exp_short);
            checkOutput($sformatf("v%0d err_long", i), o_err_long, vecs[i].exp_long);
            checkOutput($sformatf("v%0d err_timeout", i), o_err_timeout, 1'b0);
            checkOutput($sformatf("v%0d frame_count", i), o_frame_count, vecs[i].exp_fc);
            checkOutput($sformatf("v%0d err_count", i), o_err_count, vecs[i].exp_ec);
            checkOutput($sformatf("v%0d word", i), o_transaction, vecs[i].exp_word);
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("pulse width", {o_valid, o_err_short}, 2'b00);

        // Timeout in COLLECT: three bytes then silence.
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'h11 + 8'(k), 1'b0);
        early = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            noteEarly();
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("tmo early", early, 1'b0);
        checkOutput("tmo pulse", o_err_timeout, 1'b1);
        checkOutput("tmo other pulses", {o_valid, o_err_short, o_err_long}, 3'b000);
        checkOutput("tmo err_count", o_err_count, 2'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("tmo once", o_err_timeout, 1'b0);

        // Timeout in DRAIN reports only the timeout.
        for (int k = 0; k < 17; k++) applyStimulus(1'b1, 8'h70 + 8'(k), 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("drain tmo pulse", {o_err_timeout, o_err_long}, 2'b10);
        checkOutput("drain tmo err_count", o_err_count, 2'd2);

        // A byte on the fourth idle cycle beats the timeout.
        early = 1'b0;
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 8'hA0 + 8'(k), 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            noteEarly();
        end
        for (int k = 8; k < 16; k++) begin
            applyStimulus(1'b1, 8'hA0 + 8'(k), k == 15);
            if (k < 15) noteEarly();
        end
        checkOutput("race early", early, 1'b0);
        checkOutput("race valid", o_valid, 1'b1);
        checkOutput("race word", o_transaction, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        checkOutput("race counts", {o_frame_count, o_err_count}, {2'd1, 2'd2});

        // Reset mid-frame, with bytes presented during reset.
        doReset();
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 8'h30 + 8'(k), 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 8'hEE, 1'b1);
        applyStimulus(1'b1, 8'hEF, 1'b1);
        rst = 1'b0;
        checkOutput("rst pulses", {o_valid, o_err_short, o_err_long, o_err_timeout}, 4'b0000);
        checkOutput("rst counts", {o_frame_count, o_err_count}, 4'b0000);
        sendFrame(16, 8'hC0, 1'b0);
        checkOutput("rst early", early, 1'b0);
        checkOutput("rst frame valid", o_valid, 1'b1);
        checkOutput("rst frame word", o_transaction, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
        checkOutput("rst frame counts", {o_frame_count, o_err_count}, {2'd1, 2'd0});

        // Error counter saturation over five short frames.
        for (int i = 0; i < 5; i++) begin
            sendFrame(2, 8'hD0, 1'b0);
            checkOutput($sformatf("sat%0d short", i), o_err_short, 1'b1);
        end
        checkOutput("sat err_count", o_err_count, 2'b11);
        checkOutput("sat word kept", o_transaction, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);

        applyStimulus(1'b0, 8'h00, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
